// File: rtl/pwm_rampa_driver_if.sv
// Level flags in and PWM drive/status out for the ramp-start PWM driver.
// master = flag source (the ramp FSM side), slave = the driver itself.
interface pwm_rampa_driver_if #(
  parameter int DW = 7
) ();
  logic          en_30;
  logic          en_50;
  logic          en_100;
  logic          pwm_out;
  logic [DW-1:0] duty_now;
  logic          at_target;
  logic [1:0]    ramp_state;
  logic          level_err;

  modport master (
    output en_30, en_50, en_100,
    input  pwm_out, duty_now, at_target, ramp_state, level_err
  );

  modport slave (
    input  en_30, en_50, en_100,
    output pwm_out, duty_now, at_target, ramp_state, level_err
  );
endinterface

// File: rtl/pwm_rampa_driver.sv
// Slew-limited PWM driver: resolves the ramp FSM level flags into a duty target
// and moves the applied duty toward it by at most SLEW_STEP once per PWM period.
module pwm_rampa_driver #(
  parameter int PERIOD    = 100,
  parameter int DUTY_30   = 30,
  parameter int DUTY_50   = 50,
  parameter int DUTY_100  = 100,
  parameter int SLEW_STEP = 5,
  parameter int DW        = 7
) (
  input logic               clk,
  input logic               reset,
  pwm_rampa_driver_if.slave bus
);

  generate
    if (DUTY_30 > PERIOD || DUTY_50 > PERIOD || DUTY_100 > PERIOD ||
        SLEW_STEP < 1 || PERIOD < 1 || PERIOD >= (1 << DW)) begin : g_param_check
      $fatal(1, "pwm_rampa_driver: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } ramp_e;

  localparam logic [DW-1:0] PERIOD_M1 = DW'(PERIOD - 1);
  localparam logic [DW-1:0] D30       = DW'(DUTY_30);
  localparam logic [DW-1:0] D50       = DW'(DUTY_50);
  localparam logic [DW-1:0] D100      = DW'(DUTY_100);
  // A step larger than the whole period behaves the same as a full-period step
  // and stays representable in DW bits.
  localparam logic [DW-1:0] STEP      = DW'((SLEW_STEP > PERIOD) ? PERIOD : SLEW_STEP);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [DW-1:0] target;
  logic [DW-1:0] target_nxt;
  logic          level_err;
  logic [DW-1:0] cnt;
  logic [DW-1:0] duty_now;
  logic [DW-1:0] duty_nxt;
  logic          pwm_out;
  ramp_e         ramp_q;
  ramp_e         ramp_nxt;

  // Flags come from another clock phase; bit order is {en_100, en_50, en_30}.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.en_100, bus.en_50, bus.en_30};
      sync2 <= sync1;
    end
  end

  always_comb begin
    target_nxt = '0;
    if (sync2[2])
      target_nxt = D100;
    else if (sync2[1])
      target_nxt = D50;
    else if (sync2[0])
      target_nxt = D30;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target    <= '0;
      level_err <= 1'b0;
    end else begin
      target    <= target_nxt;
      level_err <= (sync2[0] & sync2[1]) | (sync2[0] & sync2[2]) | (sync2[1] & sync2[2]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt == PERIOD_M1)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Duty only moves on the last cycle of a period, so every period is driven
  // with one constant duty; the clamp keeps the step from overshooting.
  always_comb begin
    duty_nxt = duty_now;
    if (cnt == PERIOD_M1) begin
      if (duty_now < target)
        duty_nxt = ((target - duty_now) <= STEP) ? target : duty_now + STEP;
      else if (duty_now > target)
        duty_nxt = ((duty_now - target) <= STEP) ? target : duty_now - STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_now <= '0;
      pwm_out  <= 1'b0;
    end else begin
      duty_now <= duty_nxt;
      pwm_out  <= (cnt < duty_now);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ramp_q <= IDLE;
    else
      ramp_q <= ramp_nxt;
  end

  always_comb begin
    ramp_nxt = IDLE;
    if (duty_nxt < target)
      ramp_nxt = RAMP_UP;
    else if (duty_nxt > target)
      ramp_nxt = RAMP_DOWN;
  end

  always_comb begin
    bus.ramp_state = ramp_q;
    bus.at_target  = (duty_now == target);
    bus.duty_now   = duty_now;
    bus.pwm_out    = pwm_out;
    bus.level_err  = level_err;
  end

endmodule

// File: tb/tb_pwm_rampa_driver.sv
// Directed bench for pwm_rampa_driver: flag-decode vector table plus hand-built
// ramp, reset and slew-clamp sequences; DUT b runs with SLEW_STEP=7.
module tb_pwm_rampa_driver;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pwm_rampa_driver_if #(.DW(7)) if_a ();
  pwm_rampa_driver_if #(.DW(7)) if_b ();

  pwm_rampa_driver dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  pwm_rampa_driver #(.SLEW_STEP(7)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en_30;
    logic       en_50;
    logic       en_100;
    logic       exp_err;
    logic       exp_at;
    logic [1:0] exp_ramp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int dutyOf(input int sel);
    return (sel == 0) ? int'(if_a.duty_now) : int'(if_b.duty_now);
  endfunction

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic setFlags(input logic f30, input logic f50, input logic f100);
    if_a.en_30  = f30;
    if_a.en_50  = f50;
    if_a.en_100 = f100;
  endtask

  // Wait (bounded) for the selected DUT's duty to change, then compare it.
  task automatic waitDuty(input int sel, input int expv, input string name, output int waited);
    int prev;
    prev   = dutyOf(sel);
    waited = 0;
    while (dutyOf(sel) == prev && waited < 250) begin
      tick();
      waited++;
    end
    checkOutput(name, dutyOf(sel), expv);
  endtask

  task automatic countHigh(input int ncycles, output int highs);
    highs = 0;
    for (int i = 0; i < ncycles; i++) begin
      tick();
      if (if_a.pwm_out === 1'b1) highs++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = 1'b1;
    setFlags(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    setFlags(v.en_30, v.en_50, v.en_100);
    tick();
    tick();
    checkOutput({v.name, "_err_early"}, int'(if_a.level_err), 0);
    tick();
    checkOutput({v.name, "_err"}, int'(if_a.level_err), int'(v.exp_err));
    checkOutput({v.name, "_at"}, int'(if_a.at_target), int'(v.exp_at));
    checkOutput({v.name, "_ramp_early"}, int'(if_a.ramp_state), 0);
    tick();
    checkOutput({v.name, "_ramp"}, int'(if_a.ramp_state), int'(v.exp_ramp));
  endtask

  initial begin
    int waited;
    int highs;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    setFlags(1'b0, 1'b0, 1'b0);
    if_b.en_30  = 1'b0;
    if_b.en_50  = 1'b0;
    if_b.en_100 = 1'b0;

    vecs[0] = '{"none",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[1] = '{"f30",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[2] = '{"f50",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[3] = '{"f100",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[4] = '{"f30_50",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01};
    vecs[5] = '{"f30_100",  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
    vecs[6] = '{"f50_100",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
    vecs[7] = '{"f_all",    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01};

    // Idle after reset: no drive at all for 300 cycles.
    doReset();
    checkOutput("rst_duty", dutyOf(0), 0);
    checkOutput("rst_at", int'(if_a.at_target), 1);
    checkOutput("rst_ramp", int'(if_a.ramp_state), 0);
    checkOutput("rst_err", int'(if_a.level_err), 0);
    checkOutput("rst_pwm", int'(if_a.pwm_out), 0);
    countHigh(300, highs);
    checkOutput("idle_pwm_highs", highs, 0);
    checkOutput("idle_duty", dutyOf(0), 0);
    checkOutput("idle_ramp", int'(if_a.ramp_state), 0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Ramp 0 -> 30 in steps of 5.
    reset = 1'b1;
    setFlags(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    setFlags(1'b1, 1'b0, 1'b0);
    for (int d = 5; d <= 30; d += 5) begin
      waitDuty(0, d, $sformatf("up30_%0d", d), waited);
      checkOutput($sformatf("up30_gap_%0d", d), waited, 100);
    end
    checkOutput("up30_at", int'(if_a.at_target), 1);
    checkOutput("up30_ramp", int'(if_a.ramp_state), 0);
    countHigh(100, highs);
    checkOutput("pwm30_highs", highs, 30);
    countHigh(100, highs);
    checkOutput("pwm30_highs2", highs, 30);

    // 30 -> 100.
    setFlags(1'b0, 1'b0, 1'b1);
    for (int d = 35; d <= 100; d += 5)
      waitDuty(0, d, $sformatf("up100_%0d", d), waited);
    checkOutput("up100_at", int'(if_a.at_target), 1);
    countHigh(300, highs);
    checkOutput("pwm100_highs", highs, 300);

    // 100 -> 0.
    setFlags(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("down_ramp", int'(if_a.ramp_state), 2);
    for (int d = 95; d >= 0; d -= 5)
      waitDuty(0, d, $sformatf("down_%0d", d), waited);
    checkOutput("down_ramp_idle", int'(if_a.ramp_state), 0);
    countHigh(200, highs);
    checkOutput("pwm0_highs", highs, 0);

    // level_err set and release latency from a running state.
    setFlags(1'b1, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("lerr_set_early", int'(if_a.level_err), 0);
    tick();
    checkOutput("lerr_set", int'(if_a.level_err), 1);
    setFlags(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("lerr_clr_early", int'(if_a.level_err), 1);
    tick();
    checkOutput("lerr_clr", int'(if_a.level_err), 0);

    // SLEW_STEP=7 instance: last step must clamp at 30.
    setFlags(1'b0, 1'b0, 1'b0);
    doReset();
    if_b.en_30 = 1'b1;
    waitDuty(1, 7, "s7_7", waited);
    waitDuty(1, 14, "s7_14", waited);
    waitDuty(1, 21, "s7_21", waited);
    waitDuty(1, 28, "s7_28", waited);
    waitDuty(1, 30, "s7_30", waited);
    for (int i = 0; i < 200; i++) tick();
    checkOutput("s7_hold", dutyOf(1), 30);
    checkOutput("s7_at", int'(if_b.at_target), 1);
    if_b.en_30 = 1'b0;

    // Reset in the middle of a ramp toward 100, then restart toward 50.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    setFlags(1'b0, 1'b0, 1'b1);
    for (int d = 5; d <= 50; d += 5)
      waitDuty(0, d, $sformatf("pre_rst_%0d", d), waited);
    for (int i = 0; i < 37; i++) tick();
    checkOutput("pre_rst_pwm", int'(if_a.pwm_out), 1);
    checkOutput("pre_rst_ramp", int'(if_a.ramp_state), 1);
    reset = 1'b1;
    setFlags(1'b0, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_duty", dutyOf(0), 0);
    checkOutput("mid_rst_pwm", int'(if_a.pwm_out), 0);
    checkOutput("mid_rst_ramp", int'(if_a.ramp_state), 0);
    checkOutput("mid_rst_at", int'(if_a.at_target), 1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("restart_ramp", int'(if_a.ramp_state), 1);
    waitDuty(0, 5, "restart_5", waited);
    checkOutput("restart_gap", waited, 96);
    waitDuty(0, 10, "restart_10", waited);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
